// File: rtl/fft_mdc_stage.sv
// Radix-2 DIF butterfly stage for the MDC FFT: buffers half a frame, then emits (a+b, (a-b)*W[k]) pairs.
// Latency: each butterfly pair is registered one cycle after its second-half input sample is accepted.
// Backpressure: none; one sample per cycle, gaps in in_valid simply stall the frame counter and delay line.
module fft_mdc_stage #(
  parameter int WIDTH    = 9,
  parameter int DEPTH    = 16,
  parameter int TW_WIDTH = 9,
  parameter int TW_FRAC  = 7,
  parameter int SCALE    = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_sof,
  input  logic [WIDTH-1:0]    in_re,
  input  logic [WIDTH-1:0]    in_im,
  output logic [AW-1:0]       tw_idx,
  input  logic [TW_WIDTH-1:0] tw_re,
  input  logic [TW_WIDTH-1:0] tw_im,
  output logic                out_valid,
  output logic                out_sof,
  output logic [WIDTH-1:0]    out_up_re,
  output logic [WIDTH-1:0]    out_up_im,
  output logic [WIDTH-1:0]    out_lo_re,
  output logic [WIDTH-1:0]    out_lo_im,
  output logic                ovf,
  input  logic                ovf_clr
);

  localparam int CW = AW + 1;                 // frame counter spans 0..2*DEPTH-1
  localparam int SW = WIDTH + 1;              // butterfly sum/difference width
  localparam int PW = SW + TW_WIDTH + 1;      // complex product accumulator width

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_BFLY = 2'd2;

  localparam logic signed [PW-1:0] RND    = PW'(2 ** (TW_FRAC - 1));
  localparam logic signed [PW-1:0] SAT_HI = PW'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [PW-1:0] SAT_LO = PW'(-(2 ** (WIDTH - 1)));

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic signed [WIDTH-1:0] dl_re_q [DEPTH];
  logic signed [WIDTH-1:0] dl_im_q [DEPTH];

  logic bfly_fire;

  // Next frame position: in_sof always restarts (sample taken as cnt=0), otherwise advance on accepted samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (in_valid && in_sof) begin
      state_d = ST_FILL;
      cnt_d   = CW'(1);
    end else if (in_valid && state_q != ST_IDLE) begin
      if (cnt_q == CW'(2 * DEPTH - 1)) begin
        state_d = ST_FILL;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(DEPTH - 1)) ? ST_BFLY : state_q;
      end
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Delay line shifts only on accepted samples so that gaps never disturb the a/b pairing.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      dl_re_q[0] <= $signed(in_re);
      dl_im_q[0] <= $signed(in_im);
      for (int i = 1; i < DEPTH; i++) begin
        dl_re_q[i] <= dl_re_q[i-1];
        dl_im_q[i] <= dl_im_q[i-1];
      end
    end
  end

  // A restarting sample never forms a pair, even when it arrives in the second half.
  assign bfly_fire = in_valid && !in_sof && (state_q == ST_BFLY);
  assign tw_idx    = (state_q == ST_BFLY) ? cnt_q[AW-1:0] : '0;

  // Round-half-up halving when SCALE is set; the extra guard bit absorbs the +1 at the positive extreme.
  function automatic logic signed [SW-1:0] bfly_scale(input logic signed [SW:0] x);
    logic signed [SW:0] t;
    t = x + $signed((SW+1)'(1));
    if (SCALE != 0) return SW'(t >>> 1);
    return SW'(x);
  endfunction

  // Clamp to the output range; the top bit of the result flags a clamp.
  function automatic logic [WIDTH:0] sat(input logic signed [PW-1:0] x);
    if (x > SAT_HI) return {1'b1, SAT_HI[WIDTH-1:0]};
    if (x < SAT_LO) return {1'b1, SAT_LO[WIDTH-1:0]};
    return {1'b0, x[WIDTH-1:0]};
  endfunction

  logic signed [WIDTH-1:0]    a_re, a_im, b_re, b_im;
  logic signed [TW_WIDTH-1:0] w_re, w_im;
  logic signed [SW-1:0]       s_re, s_im, d_re, d_im;
  logic signed [PW-1:0]       p_re, p_im;
  logic [WIDTH:0]             up_re_s, up_im_s, lo_re_s, lo_im_s;
  logic                       sat_hit;
  logic                       ovf_q, ovf_d;

  assign a_re = dl_re_q[DEPTH-1];
  assign a_im = dl_im_q[DEPTH-1];
  assign b_re = $signed(in_re);
  assign b_im = $signed(in_im);
  assign w_re = $signed(tw_re);
  assign w_im = $signed(tw_im);

  assign s_re = bfly_scale((SW+1)'(a_re) + (SW+1)'(b_re));
  assign s_im = bfly_scale((SW+1)'(a_im) + (SW+1)'(b_im));
  assign d_re = bfly_scale((SW+1)'(a_re) - (SW+1)'(b_re));
  assign d_im = bfly_scale((SW+1)'(a_im) - (SW+1)'(b_im));

  // The multiplier sees the unsaturated difference; only the final results are clamped.
  assign p_re = PW'(d_re) * PW'(w_re) - PW'(d_im) * PW'(w_im) + RND;
  assign p_im = PW'(d_re) * PW'(w_im) + PW'(d_im) * PW'(w_re) + RND;

  assign up_re_s = sat(PW'(s_re));
  assign up_im_s = sat(PW'(s_im));
  assign lo_re_s = sat(p_re >>> TW_FRAC);
  assign lo_im_s = sat(p_im >>> TW_FRAC);
  assign sat_hit = up_re_s[WIDTH] | up_im_s[WIDTH] | lo_re_s[WIDTH] | lo_im_s[WIDTH];

  // Sticky overflow: a clamp on a produced pair wins over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (bfly_fire && sat_hit) ovf_d = 1'b1;
    else if (ovf_clr)         ovf_d = 1'b0;
  end

  logic             out_valid_q, out_sof_q;
  logic [WIDTH-1:0] up_re_q, up_im_q, lo_re_q, lo_im_q;

  // Output pair register; data holds its last value between pairs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      up_re_q     <= '0;
      up_im_q     <= '0;
      lo_re_q     <= '0;
      lo_im_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= bfly_fire;
      out_sof_q   <= bfly_fire && (cnt_q[AW-1:0] == '0);
      ovf_q       <= ovf_d;
      if (bfly_fire) begin
        up_re_q <= up_re_s[WIDTH-1:0];
        up_im_q <= up_im_s[WIDTH-1:0];
        lo_re_q <= lo_re_s[WIDTH-1:0];
        lo_im_q <= lo_im_s[WIDTH-1:0];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_up_re = up_re_q;
  assign out_up_im = up_im_q;
  assign out_lo_re = lo_re_q;
  assign out_lo_im = lo_im_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fft_mdc_stage.sv
// Bench for fft_mdc_stage: WIDTH=9, DEPTH=16, TW_FRAC=7 with an ideal twiddle ROM.
// One instance unscaled, one with SCALE=1, both fed the same stream.
// Directed frame table plus hand sequences for idle, gaps and mid-frame restart.
module tb_fft_mdc_stage;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_sof, ovf_clr;
  logic [8:0] in_re, in_im;

  logic [3:0] tw_idx0, tw_idx1;
  logic [8:0] tw_re0, tw_im0, tw_re1, tw_im1;
  logic       out_valid0, out_sof0, ovf0;
  logic       out_valid1, out_sof1, ovf1;
  logic [8:0] up_re0, up_im0, lo_re0, lo_im0;
  logic [8:0] up_re1, up_im1, lo_re1, lo_im1;

  int checks = 0;
  int errors = 0;

  // round(128*exp(-j*2*pi*k/32)), k = 0..15
  int rom_re [16] = '{128, 126, 118, 106, 91, 71, 49, 25, 0, -25, -49, -71, -91, -106, -118, -126};
  int rom_im [16] = '{0, -25, -49, -71, -91, -106, -118, -126, -128, -126, -118, -106, -91, -71, -49, -25};

  assign tw_re0 = 9'(rom_re[tw_idx0]);
  assign tw_im0 = 9'(rom_im[tw_idx0]);
  assign tw_re1 = 9'(rom_re[tw_idx1]);
  assign tw_im1 = 9'(rom_im[tw_idx1]);

  always #5 clk = ~clk;

  fft_mdc_stage #(.WIDTH(9), .DEPTH(16), .TW_WIDTH(9), .TW_FRAC(7), .SCALE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_re(in_re), .in_im(in_im),
    .tw_idx(tw_idx0), .tw_re(tw_re0), .tw_im(tw_im0), .out_valid(out_valid0), .out_sof(out_sof0),
    .out_up_re(up_re0), .out_up_im(up_im0), .out_lo_re(lo_re0), .out_lo_im(lo_im0),
    .ovf(ovf0), .ovf_clr(ovf_clr));

  fft_mdc_stage #(.WIDTH(9), .DEPTH(16), .TW_WIDTH(9), .TW_FRAC(7), .SCALE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_re(in_re), .in_im(in_im),
    .tw_idx(tw_idx1), .tw_re(tw_re1), .tw_im(tw_im1), .out_valid(out_valid1), .out_sof(out_sof1),
    .out_up_re(up_re1), .out_up_im(up_im1), .out_lo_re(lo_re1), .out_lo_im(lo_im1),
    .ovf(ovf1), .ovf_clr(ovf_clr));

  // Frame with x[k]=a, x[k+16]=b, zeros elsewhere; expected pair k (others must be zero).
  typedef struct {
    int k;
    int a_re, a_im, b_re, b_im;
    int up_re, up_im, lo_re, lo_im, ovf;
    bit chk_s;
    int s_up_re, s_up_im, s_lo_re, s_lo_im, s_ovf;
  } vec_t;

  vec_t tbl [9];

  function automatic int sx(input logic [8:0] v);
    return int'($signed(v));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Present one input cycle; tw returns tw_idx as seen before the edge. Returns #1 after the edge.
  task automatic step(input bit v, input bit sof, input int re, input int im, output int tw);
    @(negedge clk);
    in_valid = v;
    in_sof   = sof;
    in_re    = re[8:0];
    in_im    = im[8:0];
    #1 tw = int'(tw_idx0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t r, input bit clr_last, input string tag);
    int tw, re, im, kk;
    ovf_clr = 1'b1;
    step(0, 0, 0, 0, tw);
    ovf_clr = 1'b0;
    chk({tag, "_ovf_clr"}, int'(ovf0), 0);
    for (int j = 0; j < 32; j++) begin
      re = (j == r.k) ? r.a_re : (j == r.k + 16) ? r.b_re : 0;
      im = (j == r.k) ? r.a_im : (j == r.k + 16) ? r.b_im : 0;
      if (clr_last && j == 31) ovf_clr = 1'b1;
      step(1, j == 0, re, im, tw);
      ovf_clr = 1'b0;
      chk({tag, "_valid"}, int'(out_valid0), (j >= 16) ? 1 : 0);
      if (j >= 16) begin
        kk = j - 16;
        chk({tag, "_tw_idx"}, tw, kk);
        chk({tag, "_sof"}, int'(out_sof0), (kk == 0) ? 1 : 0);
        chk({tag, "_up_re"}, sx(up_re0), (kk == r.k) ? r.up_re : 0);
        chk({tag, "_up_im"}, sx(up_im0), (kk == r.k) ? r.up_im : 0);
        chk({tag, "_lo_re"}, sx(lo_re0), (kk == r.k) ? r.lo_re : 0);
        chk({tag, "_lo_im"}, sx(lo_im0), (kk == r.k) ? r.lo_im : 0);
        if (r.chk_s && kk == r.k) begin
          chk({tag, "_s_up_re"}, sx(up_re1), r.s_up_re);
          chk({tag, "_s_up_im"}, sx(up_im1), r.s_up_im);
          chk({tag, "_s_lo_re"}, sx(lo_re1), r.s_lo_re);
          chk({tag, "_s_lo_im"}, sx(lo_im1), r.s_lo_im);
        end
      end else begin
        chk({tag, "_tw_fill"}, tw, 0);
      end
    end
    chk({tag, "_ovf"}, int'(ovf0), r.ovf);
    if (r.chk_s) chk({tag, "_s_ovf"}, int'(ovf1), r.s_ovf);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int tw, nv, ns, j, cyc, re, im;
    int fr_re [64];
    int fr_im [64];
    logic [35:0] qa [$];
    logic [35:0] qb [$];
    logic [8:0]  last_up;

    //           k  a_re a_im b_re b_im  up_re up_im lo_re lo_im ovf chk_s  s_up_re s_up_im s_lo_re s_lo_im s_ovf
    tbl[0] = '{ 0,  100,   0,   0,   0,   100,    0,  100,    0,  0,  1'b1,   50,  0,  50, 0, 0};
    tbl[1] = '{ 4,   64,   0,   0,   0,    64,    0,   46,  -45,  0,  1'b0,    0,  0,   0, 0, 0};
    tbl[2] = '{ 3,  255,   0, 255,   0,   255,    0,    0,    0,  1,  1'b1,  255,  0,   0, 0, 0};
    tbl[3] = '{ 8,    0,  50,   0,  10,     0,   60,   40,    0,  0,  1'b0,    0,  0,   0, 0, 0};
    tbl[4] = '{ 1,   10,  20, -30,   5,   -20,   25,   42,    7,  0,  1'b0,    0,  0,   0, 0, 0};
    tbl[5] = '{12, -256,-256, 255, 255,    -1,   -1,    0,  255,  1,  1'b0,    0,  0,   0, 0, 0};
    tbl[6] = '{ 2,   -3,   0,   0,   0,    -3,    0,   -3,    1,  0,  1'b1,   -1,  0,  -1, 0, 0};
    tbl[7] = '{15, -200, 100, 100, -50,  -100,   50,  255,  -89,  1,  1'b0,    0,  0,   0, 0, 0};
    tbl[8] = '{10, -256,   0,-256,   0,  -256,    0,    0,    0,  1,  1'b1, -256,  0,   0, 0, 0};

    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; ovf_clr = 1'b0; in_re = '0; in_im = '0;

    // Reset state, then valid samples without sof must be ignored in IDLE.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, tw);
    chk("rst_valid", int'(out_valid0), 0);
    chk("rst_sof", int'(out_sof0), 0);
    chk("rst_ovf", int'(ovf0), 0);
    chk("rst_up_re", sx(up_re0), 0);
    chk("rst_lo_im", sx(lo_im0), 0);
    chk("rst_tw_idx", int'(tw_idx0), 0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 37 + i, -i, tw);
      chk("idle_valid", int'(out_valid0), 0);
      chk("idle_tw_idx", tw, 0);
    end
    chk("idle_up_re", sx(up_re0), 0);
    chk("idle_up_im", sx(up_im0), 0);
    chk("idle_lo_re", sx(lo_re0), 0);
    chk("idle_lo_im", sx(lo_im0), 0);

    // Directed frame table.
    for (int v = 0; v < 9; v++) run_vec(tbl[v], 1'b0, $sformatf("vec%0d", v));

    // A clamp on the last pair of the frame beats a same-cycle ovf_clr.
    run_vec(tbl[7], 1'b1, "set_over_clr");

    // Two frames gap-free, then the same frames with ~30% gaps; outputs must match.
    for (int i = 0; i < 64; i++) begin
      fr_re[i] = int'($urandom_range(200)) - 100;
      fr_im[i] = int'($urandom_range(200)) - 100;
    end
    nv = 0; ns = 0;
    for (int i = 0; i < 64; i++) begin
      step(1, (i % 32) == 0, fr_re[i], fr_im[i], tw);
      if (out_valid0) begin qa.push_back({up_re0, up_im0, lo_re0, lo_im0}); nv++; end
      if (out_sof0) ns++;
    end
    chk("nogap_valid_cnt", nv, 32);
    chk("nogap_sof_cnt", ns, 2);

    nv = 0; ns = 0; j = 0; cyc = 0;
    last_up = up_re0;
    while (j < 64 && cyc < 1000) begin
      cyc++;
      if ($urandom_range(99) < 30) begin
        step(0, 0, 0, 0, tw);
        chk("gap_valid", int'(out_valid0), 0);
        chk("gap_hold", sx(up_re0), sx(last_up));
      end else begin
        step(1, (j % 32) == 0, fr_re[j], fr_im[j], tw);
        j++;
        if (out_valid0) begin qb.push_back({up_re0, up_im0, lo_re0, lo_im0}); nv++; end
        if (out_sof0) ns++;
      end
      last_up = up_re0;
    end
    chk("gap_samples_fed", j, 64);
    chk("gap_valid_cnt", nv, 32);
    chk("gap_sof_cnt", ns, 2);
    if (qa.size() == 32 && qb.size() == 32) begin
      for (int i = 0; i < 32; i++) begin
        chk("gap_pair_up", int'(qb[i][35:18]), int'(qa[i][35:18]));
        chk("gap_pair_lo", int'(qb[i][17:0]), int'(qa[i][17:0]));
      end
    end

    // Mid-frame restart at cnt=20: the aborted frame stops, new frame starts with x[0]=100.
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, i == 0, 5, -5, tw);
      if (out_valid0) nv++;
    end
    chk("pre_abort_valid_cnt", nv, 4);
    step(1, 1, 100, 0, tw);
    chk("abort_valid", int'(out_valid0), 0);
    nv = 0;
    for (int n = 1; n < 32; n++) begin
      step(1, 0, 0, 0, tw);
      if (out_valid0) nv++;
      if (n < 16) chk("restart_fill_valid", int'(out_valid0), 0);
      if (n == 16) begin
        chk("restart_first_valid", int'(out_valid0), 1);
        chk("restart_first_sof", int'(out_sof0), 1);
        chk("restart_up_re", sx(up_re0), 100);
        chk("restart_up_im", sx(up_im0), 0);
        chk("restart_lo_re", sx(lo_re0), 100);
        chk("restart_lo_im", sx(lo_im0), 0);
      end
    end
    chk("restart_valid_cnt", nv, 16);

    in_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_mdc_stage.md
# fft_mdc_stage

Parametrised radix-2 DIF stage for the MDC FFT pipeline, built as the generalised successor of the fixed 16-deep, 9-bit first stage. It accepts one complex sample per valid cycle and buffers the first half-frame in an internal delay line. In the second half-frame it emits butterfly pairs: the upper output is a+b and the lower output is (a−b)·W[k], with rounding, optional 1/2 scaling and saturation. Frame control is internal, driven by in_valid/in_sof. Twiddles come from an external ROM through an index/data port.

## Interface
- WIDTH, 9: sample width (signed, re and im each).
- DEPTH, 16: half-frame length; power of 2, ≥2. Frame length is 2·DEPTH.
- TW_WIDTH, 9: twiddle width (signed).
- TW_FRAC, 7: twiddle fractional bits; W = round(2^TW_FRAC·exp(−j2πk/(2·DEPTH))).
- SCALE, 0: 1 means both butterfly outputs are divided by 2 (rounded) before saturation and multiply.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample accepted this cycle.
- in_sof  in  1  qualifies with in_valid; this sample is index 0 of a frame.
- in_re, in_im  in  WIDTH  signed input sample.
- tw_idx  out  log2(DEPTH)  twiddle index k, combinational from the frame counter.
- tw_re, tw_im  in  TW_WIDTH  twiddle for tw_idx, valid in the same cycle (combinational ROM).
- out_valid  out  1  output pair valid.
- out_sof  out  1  first pair of a frame.
- out_up_re, out_up_im  out  WIDTH  a+b.
- out_lo_re, out_lo_im  out  WIDTH  (a−b)·W[k].
- ovf  out  1  sticky saturation flag.
- ovf_clr  in  1  clears ovf.

## Operation
- States:
  - IDLE: entered on reset.
  - FILL: frame counter cnt in 0..DEPTH−1.
  - BFLY: cnt in DEPTH..2·DEPTH−1.
- IDLE → FILL on in_valid & in_sof; that sample is taken as cnt=0. In IDLE, in_valid without in_sof is ignored.
- Every accepted sample is written to the DEPTH-entry delay line. The line advances only on in_valid. Gaps in in_valid are legal and change no result.
- FILL: no output. Transition to BFLY after the sample at cnt=DEPTH−1.
- BFLY: a = delay-line sample x[k], b = current sample x[k+DEPTH], k = cnt−DEPTH.
- After cnt=2·DEPTH−1 the state goes to FILL with cnt=0, so streaming is continuous. in_sof on that next sample is allowed and redundant.
- in_sof with in_valid in FILL or BFLY aborts the current frame and restarts FILL with cnt=0. No further outputs are produced for the aborted frame.
- tw_idx = k in BFLY, otherwise 0.
- Arithmetic, upper path:
  - s = a+b and d = a−b, each WIDTH+1 bits.
  - If SCALE=1, s and d become (x+1)>>>1 (round half up).
  - up = sat_WIDTH(s).
- Arithmetic, lower path:
  - Complex multiply of d (unsaturated, WIDTH+1 bits) by W.
  - re = dr·wr − di·wi, im = dr·wi + di·wr.
  - Each result is (p + 2^(TW_FRAC−1)) >>> TW_FRAC, then sat_WIDTH.
- Saturation clamps to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- ovf is set on any saturation event on a valid output. It is cleared by rst or ovf_clr; set has priority over clear in the same cycle.
- out_sof is asserted with the pair for k=0.

## Timing
- All outputs are registered.
- The pair for BFLY input sample k appears with out_valid=1 one cycle after that sample is accepted.
- Frame latency: first output 1 cycle after sample DEPTH is accepted.
- Exactly DEPTH out_valid pulses per complete frame.
- out_valid=0 on cycles without an accepted BFLY sample. Data outputs hold their last value when out_valid=0.
- Reset values: all data outputs 0, out_valid 0, out_sof 0, ovf 0, tw_idx 0, state IDLE, cnt 0.
- Reset has priority over all inputs. Reset mid-frame discards the frame; delay-line contents are not cleared and need not be.
- Throughput: one sample per cycle, with no backpressure.

## Test plan
- **Reset/idle.** Assert rst, then drive in_valid=1 with in_sof=0 for 40 cycles → out_valid stays 0, all outputs 0, tw_idx=0.
- **Impulse.** WIDTH=9, DEPTH=16, TW_FRAC=7, SCALE=0, ideal ROM. Input x[0]=100+0j, others 0 → 16 pairs; k=0 gives up=(100,0), lo=(100,0), out_sof=1; k=1..15 give all zeros. First out_valid comes 1 cycle after sample 16.
- **Twiddle rounding.** x[4]=64+0j, others 0, W4=(91,−91) → pair k=4 gives lo=(46,−45) and up=(64,0).
- **Saturation.** x[3]=x[19]=255 → up_re=255 and ovf=1. Assert ovf_clr → ovf=0. Repeat with SCALE=1 → up_re=255 and ovf stays 0.
- **Gapped streaming.** Two back-to-back frames with in_valid randomly deasserted ~30% of cycles → outputs identical to the gap-free run. out_sof fires once per frame and out_valid pulses 16 times per frame.
- **Mid-frame restart.** in_sof at cnt=20 → the aborted frame produces no further outputs. The new frame yields its first pair 1 cycle after its 17th sample, with correct values.
